// File: rtl/wb_regfile.sv
// Purpose: MIPS write-back stage and 32x32 architectural register file with write-through read bypass.
// Latency: reads are combinational; a write lands in storage at the next rising clk.
// Backpressure: none; a write is accepted every cycle that wb_we is high.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-low reset
//   RegWrite_in .. PC_in   MEM/WB pipeline register outputs (enable, instruction, selects, data sources)
//   rs_addr/rs_data        ID read port A
//   rt_addr/rt_data        ID read port B
//   wb_we/wb_addr/wb_data  effective write-back triple, exported to the forwarding unit
module wb_regfile #(
  parameter int DATA_W    = 32,
  parameter int NREG_LOG2 = 5,
  parameter int LINK_REG  = 31,
  parameter int EXC_REG   = 26
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RegWrite_in,
  input  logic [31:0]          instruction_in,
  input  logic [1:0]           RegDst_in,
  input  logic [1:0]           memToReg_in,
  input  logic [DATA_W-1:0]    ALUout_in,
  input  logic [DATA_W-1:0]    readdata_in,
  input  logic [DATA_W-1:0]    PC_in,
  input  logic [NREG_LOG2-1:0] rs_addr,
  input  logic [NREG_LOG2-1:0] rt_addr,
  output logic [DATA_W-1:0]    rs_data,
  output logic [DATA_W-1:0]    rt_data,
  output logic                 wb_we,
  output logic [NREG_LOG2-1:0] wb_addr,
  output logic [DATA_W-1:0]    wb_data
);

  localparam int NREG = 1 << NREG_LOG2;
  localparam logic [NREG_LOG2-1:0] LINK_IDX = NREG_LOG2'(LINK_REG);
  localparam logic [NREG_LOG2-1:0] EXC_IDX  = NREG_LOG2'(EXC_REG);

  logic [DATA_W-1:0]    r_regs [NREG];
  logic [NREG_LOG2-1:0] w_dst;
  logic [DATA_W-1:0]    w_data;
  logic                 w_we;

  // Only the rt/rd fields of the instruction matter here.
  logic w_unused_instr;
  assign w_unused_instr = &{1'b0, instruction_in[31:21], instruction_in[10:0]};

  // Destination register select.
  always_comb begin
    w_dst = '0;
    case (RegDst_in)
      2'b00:   w_dst = NREG_LOG2'(instruction_in[20:16]);
      2'b01:   w_dst = NREG_LOG2'(instruction_in[15:11]);
      2'b10:   w_dst = LINK_IDX;
      default: w_dst = EXC_IDX;
    endcase
  end

  // Write-back data select; encoding 11 aliases the ALU result.
  always_comb begin
    w_data = ALUout_in;
    case (memToReg_in)
      2'b01:   w_data = readdata_in;
      2'b10:   w_data = PC_in;
      default: w_data = ALUout_in;
    endcase
  end

  // Writes to $0 and writes coinciding with reset are suppressed, and the
  // forwarding unit sees the same suppressed enable so it never forwards them.
  assign w_we = RegWrite_in && (w_dst != '0) && reset;

  assign wb_we   = w_we;
  assign wb_addr = w_dst;
  assign wb_data = w_data;

  // Reset wins over a coincident write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_we) begin
      r_regs[w_dst] <= w_data;
    end
  end

  // $0 is hardwired to zero; otherwise the in-flight write is bypassed so ID
  // sees the value that will be committed at the end of this cycle.
  always_comb begin
    if (rs_addr == '0) begin
      rs_data = '0;
    end else if (w_we && (rs_addr == w_dst)) begin
      rs_data = w_data;
    end else begin
      rs_data = r_regs[rs_addr];
    end
  end

  always_comb begin
    if (rt_addr == '0) begin
      rt_data = '0;
    end else if (w_we && (rt_addr == w_dst)) begin
      rt_data = w_data;
    end else begin
      rt_data = r_regs[rt_addr];
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Purpose: scoreboard bench for wb_regfile; stimulus pushes expected outputs, a monitor pops and compares.
// Latency: each stimulus cycle is observed on the falling edge of the same cycle.
// Backpressure: none; one expected entry per observed cycle.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite_in;
  logic [31:0] instruction_in;
  logic [1:0]  RegDst_in;
  logic [1:0]  memToReg_in;
  logic [31:0] ALUout_in;
  logic [31:0] readdata_in;
  logic [31:0] PC_in;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  wb_regfile dut (
    .clk            (clk),
    .reset          (reset),
    .RegWrite_in    (RegWrite_in),
    .instruction_in (instruction_in),
    .RegDst_in      (RegDst_in),
    .memToReg_in    (memToReg_in),
    .ALUout_in      (ALUout_in),
    .readdata_in    (readdata_in),
    .PC_in          (PC_in),
    .rs_addr        (rs_addr),
    .rt_addr        (rt_addr),
    .rs_data        (rs_data),
    .rt_data        (rt_data),
    .wb_we          (wb_we),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] rs;
    logic [31:0] rt;
  } exp_t;

  exp_t exp_q[$];
  logic obs_vld = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  // Monitor: compares the DUT outputs against the oldest expectation.
  always @(negedge clk) begin
    if (obs_vld) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL scoreboard_underflow: output observed with no expectation queued");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        tests_run += 4;
        if (wb_we !== e.we) begin
          tests_failed++;
          $display("FAIL %s wb_we: got %b want %b", e.name, wb_we, e.we);
        end
        if (wb_addr !== e.addr) begin
          tests_failed++;
          $display("FAIL %s wb_addr: got %0d want %0d", e.name, wb_addr, e.addr);
        end
        if (wb_data !== e.data) begin
          tests_failed++;
          $display("FAIL %s wb_data: got %h want %h", e.name, wb_data, e.data);
        end
        if (rs_data !== e.rs) begin
          tests_failed++;
          $display("FAIL %s rs_data: got %h want %h", e.name, rs_data, e.rs);
        end
        if (rt_data !== e.rt) begin
          tests_failed++;
          $display("FAIL %s rt_data: got %h want %h", e.name, rt_data, e.rt);
        end
      end
    end
  end

  task automatic step(input string name, input logic rst_n, input logic rw,
                      input logic [1:0] rdst, input logic [1:0] m2r, input logic [31:0] instr,
                      input logic [31:0] alu, input logic [31:0] rdat, input logic [31:0] pc,
                      input logic [4:0] rsa, input logic [4:0] rta,
                      input logic e_we, input logic [4:0] e_addr, input logic [31:0] e_data,
                      input logic [31:0] e_rs, input logic [31:0] e_rt);
    exp_t e;
    @(posedge clk);
    #1;
    reset          = rst_n;
    RegWrite_in    = rw;
    RegDst_in      = rdst;
    memToReg_in    = m2r;
    instruction_in = instr;
    ALUout_in      = alu;
    readdata_in    = rdat;
    PC_in          = pc;
    rs_addr        = rsa;
    rt_addr        = rta;
    e.name = name; e.we = e_we; e.addr = e_addr; e.data = e_data; e.rs = e_rs; e.rt = e_rt;
    exp_q.push_back(e);
    obs_vld = 1'b1;
  endtask

  // Idle MEM/WB (bubble) while reading: triple is {0, 0, 0}.
  task automatic rd_step(input string name, input logic [4:0] rsa, input logic [4:0] rta,
                         input logic [31:0] e_rs, input logic [31:0] e_rt);
    step(name, 1'b1, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, rsa, rta,
         1'b0, 5'd0, 32'h0, e_rs, e_rt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; RegWrite_in = 1'b0; instruction_in = '0; RegDst_in = '0; memToReg_in = '0;
    ALUout_in = '0; readdata_in = '0; PC_in = '0; rs_addr = '0; rt_addr = '0;
    repeat (2) @(posedge clk);

    // Power-up state after reset.
    rd_step("por_read", 5'd5, 5'd31, 32'h0, 32'h0);

    // ALU write via rd=8, bypass on port B.
    step("alu_rd8", 1'b1, 1'b1, 2'b01, 2'b00, 32'h0000_4000, 32'h1234, 32'h0, 32'h0, 5'd0, 5'd8,
         1'b1, 5'd8, 32'h1234, 32'h0, 32'h1234);
    rd_step("alu_rd8_read", 5'd8, 5'd9, 32'h1234, 32'h0);

    // Load via rt=9 (rd field 7 must be ignored), both ports bypass.
    step("load_rt9", 1'b1, 1'b1, 2'b00, 2'b01, 32'h0009_3800, 32'h5555_5555, 32'hCAFE_F00D, 32'h0,
         5'd9, 5'd9, 1'b1, 5'd9, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'hCAFE_F00D);
    rd_step("load_rt9_read", 5'd9, 5'd7, 32'hCAFE_F00D, 32'h0);

    // memToReg=11 selects the ALU result.
    step("m2r11_rd10", 1'b1, 1'b1, 2'b01, 2'b11, 32'h0000_5000, 32'h0000_A5A5, 32'h1111_1111,
         32'h2222_2222, 5'd10, 5'd8, 1'b1, 5'd10, 32'h0000_A5A5, 32'h0000_A5A5, 32'h1234);

    // Link and exception destinations.
    step("link_r31", 1'b1, 1'b1, 2'b10, 2'b10, 32'h0, 32'h9999_9999, 32'h0, 32'h0040_0010,
         5'd10, 5'd31, 1'b1, 5'd31, 32'h0040_0010, 32'h0000_A5A5, 32'h0040_0010);
    step("exc_r26", 1'b1, 1'b1, 2'b11, 2'b10, 32'h0, 32'h0, 32'h0, 32'h8000_0004,
         5'd31, 5'd26, 1'b1, 5'd26, 32'h8000_0004, 32'h0040_0010, 32'h8000_0004);
    rd_step("link_exc_read", 5'd31, 5'd26, 32'h0040_0010, 32'h8000_0004);

    // $0 guard.
    step("zero_write", 1'b1, 1'b1, 2'b01, 2'b00, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd0, 5'd0,
         1'b0, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0);
    rd_step("zero_read", 5'd0, 5'd0, 32'h0, 32'h0);

    // Write reg4, then RegWrite=0 with rd=4 must leave it alone.
    step("w_r4", 1'b1, 1'b1, 2'b01, 2'b00, 32'h0000_2000, 32'h44, 32'h0, 32'h0, 5'd0, 5'd0,
         1'b1, 5'd4, 32'h44, 32'h0, 32'h0);
    step("nowrite_r4", 1'b1, 1'b0, 2'b01, 2'b00, 32'h0000_2000, 32'h77, 32'h0, 32'h0, 5'd4, 5'd4,
         1'b0, 5'd4, 32'h77, 32'h44, 32'h44);
    rd_step("r4_kept", 5'd4, 5'd9, 32'h44, 32'hCAFE_F00D);

    // Write reg5, then reset for two edges; the first carries a write to reg3.
    step("w_r5", 1'b1, 1'b1, 2'b01, 2'b00, 32'h0000_2800, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd0, 5'd0,
         1'b1, 5'd5, 32'hDEAD_BEEF, 32'h0, 32'h0);
    rd_step("r5_read", 5'd5, 5'd8, 32'hDEAD_BEEF, 32'h1234);
    step("rst_vs_w_r3", 1'b0, 1'b1, 2'b01, 2'b00, 32'h0000_1800, 32'h7, 32'h0, 32'h0, 5'd3, 5'd5,
         1'b0, 5'd3, 32'h7, 32'h0, 32'hDEAD_BEEF);
    step("rst_hold", 1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0,
         1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 32; i++) begin
      rd_step("rst_read_all", 5'(i), 5'(31 - i), 32'h0, 32'h0);
    end

    // Bubble causes no state change.
    step("bubble", 1'b1, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 5'd3, 5'd5,
         1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    rd_step("after_bubble", 5'd3, 5'd26, 32'h0, 32'h0);

    @(posedge clk);
    #1;
    obs_vld = 1'b0;
    @(posedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Write-back stage and architectural register file of the 5-stage MIPS pipeline, directly downstream of the MEM/WB pipeline register. It consumes the MEM/WB outputs and selects write-back data and destination register. It commits the result into a 32x32 register file and serves the two ID-stage read ports with same-cycle write-through bypass. It also exports the current write-back triple for the hazard/forwarding unit.

Parameters:
DATA_W, 32, register and data width
NREG_LOG2, 5, register address width (32 registers)
LINK_REG, 31, destination index when RegDst = 2'b10 (jal/jalr link)
EXC_REG, 26, destination index when RegDst = 2'b11 ($k0, exception return PC)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
RegWrite_in  input  1  write enable from MEM/WB
instruction_in  input  32  instruction from MEM/WB; rt = [20:16], rd = [15:11]
RegDst_in  input  2  destination select: 00 rt, 01 rd, 10 LINK_REG, 11 EXC_REG
memToReg_in  input  2  data select: 00 ALU result, 01 load data, 10 link/PC value, 11 ALU result
ALUout_in  input  32  ALU result from MEM/WB
readdata_in  input  32  load data from MEM/WB
PC_in  input  32  PC value from MEM/WB; already PC+4, written unmodified
rs_addr  input  5  ID read port A address
rt_addr  input  5  ID read port B address
rs_data  output  32  read port A data (combinational)
rt_data  output  32  read port B data (combinational)
wb_we  output  1  effective write enable this cycle (to forwarding unit)
wb_addr  output  5  effective destination register
wb_data  output  32  selected write-back data

Behaviour:
- Reset (reset = 0 at a rising clk edge): all 32 registers cleared to 0. Reset has priority over a coincident write; that write is dropped. Reset is synchronous only; reset asserting between edges changes nothing until the next edge.
- Outputs are combinational from inputs plus register state, so there is no output reset value. After reset, rs_data = rt_data = 0 for any address unless bypassed.
- Destination mux: RegDst_in 00 -> instruction_in[20:16], 01 -> instruction_in[15:11], 10 -> LINK_REG, 11 -> EXC_REG.
- Data mux: memToReg_in 00/11 -> ALUout_in, 01 -> readdata_in, 10 -> PC_in.
- wb_addr = mux result; wb_data = mux result; wb_we = RegWrite_in AND (wb_addr != 0) AND reset.
- Write: at rising clk, if reset = 1 and wb_we = 1, reg[wb_addr] <= wb_data. Latency 1 cycle to storage.
- $0: reads always return 0; writes to $0 are ignored and wb_we is forced 0. Register 0 storage never becomes nonzero.
- Read ports are asynchronous: rs_data = reg[rs_addr], rt_data = reg[rt_addr].
- Write-through bypass: if wb_we = 1 and rs_addr == wb_addr, rs_data = wb_data in the same cycle. The same rule applies independently to port B. This removes the WB->ID hazard so ID sees the value committed at the end of this cycle.
- Both read ports may hit the same register, including the one being written; both return the bypassed value.
- A MEM/WB bubble (cleared register: RegWrite 0, instruction 0) yields wb_we = 0 and causes no state change.
- No X propagation: unused mux encodings resolve as listed above.

Test Plan:
- Reset: hold reset = 0 for 2 edges after writing reg[5] = 32'hDEADBEEF -> read reg[5] = 0; all 31 regs read 0.
- ALU write via rd: RegWrite = 1, RegDst = 01, instr rd = 8, memToReg = 00, ALUout = 32'h1234 -> after edge, rs_addr = 8 gives 32'h1234. During the write cycle, rt_addr = 8 bypasses 32'h1234.
- Load via rt: RegDst = 00, rt = 9, memToReg = 01, readdata = 32'hCAFEF00D -> reg[9] = 32'hCAFEF00D; ALUout ignored.
- Link/exception: RegDst = 10, memToReg = 10, PC_in = 32'h00400010 -> reg[31] = 32'h00400010. RegDst = 11 with PC_in = 32'h80000004 -> reg[26] = 32'h80000004.
- $0 guard: RegWrite = 1, rd = 0, ALUout = 32'hFFFFFFFF -> wb_we = 0, reads of $0 = 0 in the same cycle and afterwards.
- Reset vs write collision: reset = 0 and a write to reg[3] = 7 on the same edge -> reg[3] = 0; RegWrite = 0 with rd = 4 -> reg[4] unchanged.
